fifo_ram_ctrl: RTL and testbench
================================

Name:
fifo_ram_ctrl

Overview:
- Synchronous FIFO controller that acts as the initiator side of the team's 16x8 synchronous dual-port RAM.
- Converts a push/pop client interface into RAM write/read port strobes and addresses.
- Tracks occupancy with wrap-bit pointers and flags full, empty and threshold conditions.
- Storage lives in the external RAM; this block holds pointers, count and flags only.

Parameters:
RAM_WIDTH, 8, data width in bits
RAM_DEPTH, 16, number of entries; must equal 2**ADDR_SIZE
ADDR_SIZE, 4, RAM address width
AFULL_THRESH, 12, almost_full asserts when count >= this value
AEMPTY_THRESH, 4, almost_empty asserts when count <= this value

Ports:
clk  input  1  single clock; all state updates on rising edge
rst  input  1  asynchronous, active-high reset
push  input  1  client write request
push_data  input  RAM_WIDTH  data to enqueue
pop  input  1  client read request
pop_data  output  RAM_WIDTH  dequeued data; pass-through of ram_data_out
pop_valid  output  1  registered; high for the cycle after an accepted pop
full  output  1  count == RAM_DEPTH
empty  output  1  count == 0
almost_full  output  1  count >= AFULL_THRESH
almost_empty  output  1  count <= AEMPTY_THRESH
count  output  ADDR_SIZE+1  current occupancy, 0..RAM_DEPTH
overflow  output  1  one-cycle registered pulse: push rejected
underflow  output  1  one-cycle registered pulse: pop rejected
ram_wr_enb  output  1  to RAM wr_enb
ram_wr_addr  output  ADDR_SIZE  to RAM wr_addr
ram_data_in  output  RAM_WIDTH  to RAM data_in
ram_rd_enb  output  1  to RAM rd_enb
ram_rd_addr  output  ADDR_SIZE  to RAM rd_addr
ram_data_out  input  RAM_WIDTH  from RAM data_out; registered by the RAM, 1-cycle latency

Behaviour:
- Pointers: wr_ptr and rd_ptr are ADDR_SIZE+1 bits wide.
  - empty when the pointers are equal.
  - full when the MSBs differ and the low ADDR_SIZE bits are equal.
  - count = wr_ptr - rd_ptr, modulo 2**(ADDR_SIZE+1).
  - All flags decode from registered state only.
- Accept rules:
  - push_acc = push & ~full; pop_acc = pop & ~empty. Both use flags as they stand before the edge.
  - On an accepted push, wr_ptr increments. On an accepted pop, rd_ptr increments.
  - The low bits wrap 15 -> 0 and the wrap bit toggles.
- RAM drive (combinational):
  - ram_wr_enb = push_acc; ram_wr_addr = wr_ptr[ADDR_SIZE-1:0]; ram_data_in = push_data.
  - ram_rd_enb = pop_acc; ram_rd_addr = rd_ptr[ADDR_SIZE-1:0].
- Read latency: pop accepted at edge N -> pop_valid=1 and pop_data valid during cycle N+1. No show-ahead.
- Simultaneous push and pop:
  - Neither full nor empty: both accepted, count unchanged.
  - Full: pop accepted, push rejected, overflow pulses.
  - Empty: push accepted, pop rejected, underflow pulses. No write-to-read bypass.
- Write-then-read: an entry written at edge N may be popped from cycle N+1. Its read occurs at edge N+1 or later and returns the new data.
- Rejected push: no RAM write, pointers held, overflow=1 for exactly one cycle after the edge.
- Rejected pop: no RAM read, pop_valid stays 0, underflow=1 for exactly one cycle after the edge.
- Reset values (async assert, sync deassert assumed upstream):
  - wr_ptr=0, rd_ptr=0, count=0.
  - empty=1, almost_empty=1, full=0, almost_full=0.
  - pop_valid=0, overflow=0, underflow=0.
  - RAM contents are not cleared.
- Reset mid-operation: any in-flight pop_valid is killed immediately. Pointers are discarded. After release the FIFO is empty.

Test Plan:
- Reset: assert rst asynchronously mid-cycle -> empty=1, count=0, pop_valid=0 immediately, before any clk edge.
- Fill/drain: push 0x10..0x1F on 16 consecutive cycles -> full=1, count=16, almost_full from count 12. Then pop 16 -> pop_data 0x10..0x1F in order, one cycle after each pop, then empty=1.
- Overflow: at full, push 0xAA -> overflow pulses 1 cycle, ram_wr_enb=0, count=16. Subsequent drain returns no 0xAA.
- Underflow: when empty, pop -> underflow pulses 1 cycle, ram_rd_enb=0, pop_valid=0, count=0.
- Simultaneous: with count=5, push and pop together for 20 cycles -> count stays 5, data order preserved across the address wrap 15 -> 0. At full, push+pop -> count 15. At empty, push+pop -> count 1, no pop_valid.
- Reset during drain: with count=8, pop at edge N and assert rst in cycle N+1 -> pop_valid=0 immediately. After release, push 0x55 then pop -> pop_data=0x55.

Source files
------------

// File: rtl/fifo_ram_ctrl.sv
// FIFO controller driving an external 16x8 synchronous dual-port RAM.
// Only the pointers, status pulses and flag decode live here; the data is held in the RAM.
module fifo_ram_ctrl #(
  parameter int RAM_WIDTH     = 8,
  parameter int RAM_DEPTH     = 16,
  parameter int ADDR_SIZE     = 4,
  parameter int AFULL_THRESH  = 12,
  parameter int AEMPTY_THRESH = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 push,
  input  logic [RAM_WIDTH-1:0] push_data,
  input  logic                 pop,
  output logic [RAM_WIDTH-1:0] pop_data,
  output logic                 pop_valid,
  output logic                 full,
  output logic                 empty,
  output logic                 almost_full,
  output logic                 almost_empty,
  output logic [ADDR_SIZE:0]   count,
  output logic                 overflow,
  output logic                 underflow,
  output logic                 ram_wr_enb,
  output logic [ADDR_SIZE-1:0] ram_wr_addr,
  output logic [RAM_WIDTH-1:0] ram_data_in,
  output logic                 ram_rd_enb,
  output logic [ADDR_SIZE-1:0] ram_rd_addr,
  input  logic [RAM_WIDTH-1:0] ram_data_out
);

  localparam int PW = ADDR_SIZE + 1;

  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic          pop_valid_q, pop_valid_d;
  logic          overflow_q, overflow_d;
  logic          underflow_q, underflow_d;
  logic          push_acc, pop_acc;

  // Occupancy and flags come from the registered pointers only. The extra wrap
  // bit makes count reach RAM_DEPTH exactly when the wrap bits differ and the
  // address bits match.
  assign count        = wr_ptr_q - rd_ptr_q;
  assign empty        = (wr_ptr_q == rd_ptr_q);
  assign full         = (count == PW'(RAM_DEPTH));
  assign almost_full  = (count >= PW'(AFULL_THRESH));
  assign almost_empty = (count <= PW'(AEMPTY_THRESH));

  assign push_acc = push & ~full;
  assign pop_acc  = pop & ~empty;

  assign ram_wr_enb  = push_acc;
  assign ram_wr_addr = wr_ptr_q[ADDR_SIZE-1:0];
  assign ram_data_in = push_data;
  assign ram_rd_enb  = pop_acc;
  assign ram_rd_addr = rd_ptr_q[ADDR_SIZE-1:0];

  // The RAM registers its read data, so it lines up with pop_valid with no extra staging.
  assign pop_data  = ram_data_out;
  assign pop_valid = pop_valid_q;
  assign overflow  = overflow_q;
  assign underflow = underflow_q;

  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    if (push_acc) wr_ptr_d = wr_ptr_q + PW'(1);
    if (pop_acc)  rd_ptr_d = rd_ptr_q + PW'(1);
    pop_valid_d = pop_acc;
    overflow_d  = push & full;
    underflow_d = pop & empty;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      pop_valid_q <= 1'b0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      pop_valid_q <= pop_valid_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

endmodule

// File: tb/tb_fifo_ram_ctrl.sv
// Randomized and directed bench for fifo_ram_ctrl with a behavioural RAM and a
// queue-based reference FIFO.
module tb_fifo_ram_ctrl;
  localparam int W  = 8;
  localparam int D  = 16;
  localparam int A  = 4;
  localparam int AF = 12;
  localparam int AE = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         push = 1'b0, pop = 1'b0;
  logic [W-1:0] push_data = '0;
  logic [W-1:0] pop_data;
  logic         pop_valid, full, empty, almost_full, almost_empty;
  logic [A:0]   count;
  logic         overflow, underflow;
  logic         ram_wr_enb, ram_rd_enb;
  logic [A-1:0] ram_wr_addr, ram_rd_addr;
  logic [W-1:0] ram_data_in;
  logic [W-1:0] ram_data_out = '0;

  fifo_ram_ctrl #(
    .RAM_WIDTH(W), .RAM_DEPTH(D), .ADDR_SIZE(A),
    .AFULL_THRESH(AF), .AEMPTY_THRESH(AE)
  ) dut (
    .clk(clk), .rst(rst), .push(push), .push_data(push_data), .pop(pop),
    .pop_data(pop_data), .pop_valid(pop_valid), .full(full), .empty(empty),
    .almost_full(almost_full), .almost_empty(almost_empty), .count(count),
    .overflow(overflow), .underflow(underflow), .ram_wr_enb(ram_wr_enb),
    .ram_wr_addr(ram_wr_addr), .ram_data_in(ram_data_in), .ram_rd_enb(ram_rd_enb),
    .ram_rd_addr(ram_rd_addr), .ram_data_out(ram_data_out)
  );

  always #5 clk = ~clk;

  // Behavioural 16x8 dual-port RAM with registered read data.
  logic [W-1:0] mem [D];
  always @(posedge clk) begin
    if (ram_wr_enb) mem[ram_wr_addr] <= ram_data_in;
    if (ram_rd_enb) ram_data_out <= mem[ram_rd_addr];
  end

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  // Reference model: a queue of stored bytes plus lifetime push/pop totals.
  logic [W-1:0] q[$];
  int unsigned  wr_tot = 0, rd_tot = 0;

  task automatic model_reset();
    q.delete();
    wr_tot = 0;
    rd_tot = 0;
  endtask

  task automatic chk_flags();
    int n;
    n = q.size();
    chk("count", 32'(count), 32'(n));
    chk("empty", 32'(empty), 32'(n == 0));
    chk("full", 32'(full), 32'(n == D));
    chk("almost_full", 32'(almost_full), 32'(n >= AF));
    chk("almost_empty", 32'(almost_empty), 32'(n <= AE));
  endtask

  // One clock: drive at negedge, check RAM strobes before the edge, then the
  // registered results just after it.
  task automatic step(input bit p, input logic [W-1:0] d, input bit r);
    bit pa, ra;
    logic [W-1:0] exp_pd;
    exp_pd = '0;
    @(negedge clk);
    push = p; push_data = d; pop = r;
    #1;
    pa = p && (q.size() < D);
    ra = r && (q.size() > 0);
    chk("ram_wr_enb", 32'(ram_wr_enb), 32'(pa));
    chk("ram_rd_enb", 32'(ram_rd_enb), 32'(ra));
    if (pa) begin
      chk("ram_wr_addr", 32'(ram_wr_addr), wr_tot % D);
      chk("ram_data_in", 32'(ram_data_in), 32'(d));
    end
    if (ra) chk("ram_rd_addr", 32'(ram_rd_addr), rd_tot % D);
    if (ra) begin exp_pd = q.pop_front(); rd_tot++; end
    if (pa) begin q.push_back(d); wr_tot++; end
    @(posedge clk);
    #1;
    chk("pop_valid", 32'(pop_valid), 32'(ra));
    chk("overflow", 32'(overflow), 32'(p && !pa));
    chk("underflow", 32'(underflow), 32'(r && !ra));
    if (ra) chk("pop_data", 32'(pop_data), 32'(exp_pd));
    chk_flags();
  endtask

  task automatic apply_reset();
    @(negedge clk);
    push = 0; pop = 0;
    rst = 1'b1;
    model_reset();
    #1;
    chk("rst_empty", 32'(empty), 32'd1);
    chk("rst_pop_valid", 32'(pop_valid), 32'd0);
    chk_flags();
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    // Power-up reset; the initial 0->1 transition exercises the async path.
    #1 rst = 1'b1;
    #1;
    chk("por_empty", 32'(empty), 32'd1);
    chk("por_count", 32'(count), 32'd0);
    chk("por_pop_valid", 32'(pop_valid), 32'd0);
    chk("por_overflow", 32'(overflow), 32'd0);
    chk("por_underflow", 32'(underflow), 32'd0);
    chk_flags();
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Fill 0x10..0x1F, overflow at full, push+pop at full, then drain.
    for (int i = 0; i < D; i++) step(1'b1, W'(8'h10 + i), 1'b0);
    step(1'b1, 8'hAA, 1'b0);
    step(1'b0, 8'h00, 1'b0);
    step(1'b1, 8'h20, 1'b1);
    while (q.size() > 0) step(1'b0, 8'h00, 1'b1);
    step(1'b0, 8'h00, 1'b0);

    // Underflow, then push+pop while empty.
    step(1'b0, 8'h00, 1'b1);
    step(1'b0, 8'h00, 1'b0);
    step(1'b1, 8'h33, 1'b1);
    step(1'b0, 8'h00, 1'b1);

    // Steady count of 5 through the address wrap.
    for (int i = 0; i < 5; i++) step(1'b1, W'(8'h40 + i), 1'b0);
    for (int i = 0; i < 20; i++) step(1'b1, W'(8'h60 + i), 1'b1);
    while (q.size() > 0) step(1'b0, 8'h00, 1'b1);

    // Async reset while a pop result is in flight.
    for (int i = 0; i < 8; i++) step(1'b1, W'(8'h80 + i), 1'b0);
    step(1'b0, 8'h00, 1'b1);
    #1 rst = 1'b1;
    #1;
    chk("mid_rst_pop_valid", 32'(pop_valid), 32'd0);
    chk("mid_rst_empty", 32'(empty), 32'd1);
    chk("mid_rst_count", 32'(count), 32'd0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    step(1'b1, 8'h55, 1'b0);
    step(1'b0, 8'h00, 1'b1);
    step(1'b0, 8'h00, 1'b0);

    // Random traffic with changing push/pop bias to sweep occupancy.
    for (int ph = 0; ph < 8; ph++) begin
      int pb, rb;
      pb = (ph % 2 == 0) ? 75 : 30;
      rb = (ph % 2 == 0) ? 30 : 75;
      if (ph == 6) begin pb = 50; rb = 50; end
      for (int c = 0; c < 80; c++)
        step($urandom_range(0, 99) < pb, W'($urandom), $urandom_range(0, 99) < rb);
    end
    apply_reset();
    for (int c = 0; c < 100; c++)
      step($urandom_range(0, 1) == 1, W'($urandom), $urandom_range(0, 1) == 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
